hazard_unit: RTL and testbench

Pipeline hazard and stall controller sitting in the ID stage, directly upstream of the forwarding unit. It decides, each cycle, whether the PC, IF/ID and ID/EXE registers advance, hold or are flushed, so that the instruction presented to the forwarding unit in ID/EXE is always valid or an explicit bubble. It covers three hazards: load-use stalls, taken-branch/jump flushes and multi-cycle divide freezes. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 180 ++++++++++++++++++
 tb/tb_hazard_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
// ID-stage stall/flush controller. Decides each cycle whether the PC, IF/ID
// and ID/EXE registers advance, hold or are flushed. Three hazards are
// covered, in priority order: multi-cycle divide freeze, taken
// branch/jump redirect, and load-use. A saturating counter records the
// number of cycles in which the PC was held.
//
// Control outputs are combinational from the current state and inputs, so a
// hazard is answered in the same cycle it appears. While rstn is low the
// outputs are forced to their pass-through values regardless of the inputs.

`ifndef DMRd_NOP
`define DMRd_NOP 3'b000
`endif

module hazard_unit #(
    parameter int DIV_LAT = 8,   // cycles a divide occupies EXE, 2..255
    parameter int CNT_W   = 16   // width of the stall performance counter
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_use_rs,
    input  logic             IFID_use_rt,
    input  logic [2:0]       IDEXE_DMRd,
    input  logic             IDEXE_RFWr,
    input  logic [4:0]       IDEXE_rd,
    input  logic             EXE_div,
    input  logic             EXE_redirect,
    output logic             PCWr,
    output logic             IFIDWr,
    output logic             IDEXEWr,
    output logic             IFID_flush,
    output logic             IDEXE_flush,
    output logic             EXEMEM_flush,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    // The first freeze cycle is spent in IDLE and the final EXE cycle is the
    // non-frozen release cycle, hence the two subtracted from DIV_LAT.
    localparam logic [7:0]       DIV_CNT_INIT = 8'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] STALL_MAX    = {CNT_W{1'b1}};

    state_t           state_r;
    logic [7:0]       cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic freeze_s;
    logic redirect_s;
    logic load_use_s;
    logic lu_hit_s;

    // True when the EXE instruction is a load whose destination is read by
    // the ID instruction. r0 is never a real dependency; r31 is.
    function automatic logic load_use_hit(
        input logic [2:0] dmrd,
        input logic       rfwr,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic       use_rs,
        input logic [4:0] rt,
        input logic       use_rt
    );
        logic is_load;
        logic dep_rs;
        logic dep_rt;
        is_load = (dmrd != `DMRd_NOP) && rfwr && (rd != 5'd0);
        dep_rs  = use_rs && (rd == rs);
        dep_rt  = use_rt && (rd == rt);
        return is_load && (dep_rs || dep_rt);
    endfunction

    // Freeze is active on the first divide cycle and while the countdown runs.
    always_comb begin
        freeze_s = 1'b0;
        case (state_r)
            IDLE:     freeze_s = EXE_div;
            DIV_BUSY: freeze_s = (cnt_r != 8'd0);
            default:  freeze_s = 1'b0;
        endcase
    end

    // Qualify lower-priority hazards against the higher-priority ones.
    always_comb begin
        lu_hit_s   = load_use_hit(IDEXE_DMRd, IDEXE_RFWr, IDEXE_rd,
                                  IFID_rs, IFID_use_rs, IFID_rt, IFID_use_rt);
        redirect_s = EXE_redirect && !freeze_s;
        load_use_s = lu_hit_s && !freeze_s && !EXE_redirect;
    end

    // Pipeline-register enables and flushes; pass-through while in reset.
    always_comb begin
        PCWr         = 1'b1;
        IFIDWr       = 1'b1;
        IDEXEWr      = 1'b1;
        IFID_flush   = 1'b0;
        IDEXE_flush  = 1'b0;
        EXEMEM_flush = 1'b0;
        div_busy     = 1'b0;
        if (!rstn) begin
            PCWr         = 1'b1;
            IFIDWr       = 1'b1;
            IDEXEWr      = 1'b1;
        end else if (freeze_s) begin
            // Hold everything upstream of EXE and feed bubbles into MEM.
            PCWr         = 1'b0;
            IFIDWr       = 1'b0;
            IDEXEWr      = 1'b0;
            EXEMEM_flush = 1'b1;
            div_busy     = 1'b1;
        end else if (redirect_s) begin
            // PC loads the target; the two wrong-path instructions are killed.
            IFID_flush   = 1'b1;
            IDEXE_flush  = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID one cycle; the bubble removes the dependency.
            PCWr         = 1'b0;
            IFIDWr       = 1'b0;
            IDEXE_flush  = 1'b1;
        end else begin
            PCWr         = 1'b1;
            IFIDWr       = 1'b1;
        end
    end

    // Divide freeze sequencer: load the countdown on entry, release at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (EXE_div) begin
                        state_r <= DIV_BUSY;
                        cnt_r   <= DIV_CNT_INIT;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_r != 8'd0) begin
                        state_r <= DIV_BUSY;
                        cnt_r   <= cnt_r - 8'd1;
                    end else begin
                        // Release cycle: the divide advances out of EXE now.
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_r <= '0;
        end else if (!PCWr && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit. Two instances share the same stimulus:
// one with DIV_LAT=8/CNT_W=16 and one with DIV_LAT=3/CNT_W=4 (saturation).
// Expected responses come from a cycle-level model that tracks how long the
// current divide has sat in EXE, rather than any state machine encoding.

`ifndef DMRd_NOP
`define DMRd_NOP 3'b000
`endif

module tb_hazard_unit;

    localparam int LAT_A = 8;
    localparam int W_A   = 16;
    localparam int LAT_B = 3;
    localparam int W_B   = 4;

    logic       clk;
    logic       rstn;
    logic [4:0] IFID_rs;
    logic [4:0] IFID_rt;
    logic       IFID_use_rs;
    logic       IFID_use_rt;
    logic [2:0] IDEXE_DMRd;
    logic       IDEXE_RFWr;
    logic [4:0] IDEXE_rd;
    logic       EXE_div;
    logic       EXE_redirect;

    logic           pcwr_a, ifidwr_a, idexewr_a, ifid_fl_a, idexe_fl_a, exemem_fl_a, busy_a;
    logic [W_A-1:0] stall_a;
    logic           pcwr_b, ifidwr_b, idexewr_b, ifid_fl_b, idexe_fl_b, exemem_fl_b, busy_b;
    logic [W_B-1:0] stall_b;

    hazard_unit #(.DIV_LAT(LAT_A), .CNT_W(W_A)) dut (
        .clk(clk), .rstn(rstn),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IFID_use_rs(IFID_use_rs), .IFID_use_rt(IFID_use_rt),
        .IDEXE_DMRd(IDEXE_DMRd), .IDEXE_RFWr(IDEXE_RFWr), .IDEXE_rd(IDEXE_rd),
        .EXE_div(EXE_div), .EXE_redirect(EXE_redirect),
        .PCWr(pcwr_a), .IFIDWr(ifidwr_a), .IDEXEWr(idexewr_a),
        .IFID_flush(ifid_fl_a), .IDEXE_flush(idexe_fl_a), .EXEMEM_flush(exemem_fl_a),
        .div_busy(busy_a), .stall_cycles(stall_a)
    );

    hazard_unit #(.DIV_LAT(LAT_B), .CNT_W(W_B)) dut_sat (
        .clk(clk), .rstn(rstn),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IFID_use_rs(IFID_use_rs), .IFID_use_rt(IFID_use_rt),
        .IDEXE_DMRd(IDEXE_DMRd), .IDEXE_RFWr(IDEXE_RFWr), .IDEXE_rd(IDEXE_rd),
        .EXE_div(EXE_div), .EXE_redirect(EXE_redirect),
        .PCWr(pcwr_b), .IFIDWr(ifidwr_b), .IDEXEWr(idexewr_b),
        .IFID_flush(ifid_fl_b), .IDEXE_flush(idexe_fl_b), .EXEMEM_flush(exemem_fl_b),
        .div_busy(busy_b), .stall_cycles(stall_b)
    );

    typedef struct {
        logic [6:0] ctrl_a;
        int         stall_a;
        logic [6:0] ctrl_b;
        int         stall_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // model state: cycles the current divide has spent in EXE, stall count
    int age_a = 0, stl_a = 0;
    int age_b = 0, stl_b = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {PCWr,IFIDWr,IDEXEWr,IFID_flush,IDEXE_flush,EXEMEM_flush,div_busy}
    task automatic model(input int lat, input int w, inout int age, inout int stall,
                         output logic [6:0] ctrl, output int exp_stall);
        bit freeze, load_use, dep;
        if (!rstn) begin
            age       = 0;
            stall     = 0;
            ctrl      = 7'b1110000;
            exp_stall = 0;
        end else begin
            // a divide freezes for its first lat-1 cycles in EXE
            if (age == 0) freeze = EXE_div;
            else          freeze = (age < lat - 1);
            dep = (IFID_use_rs && IDEXE_rd == IFID_rs) || (IFID_use_rt && IDEXE_rd == IFID_rt);
            load_use = (IDEXE_DMRd != `DMRd_NOP) && IDEXE_RFWr && (IDEXE_rd != 5'd0) && dep;
            if (freeze)            ctrl = 7'b0000011;
            else if (EXE_redirect) ctrl = 7'b1111100;
            else if (load_use)     ctrl = 7'b0010100;
            else                   ctrl = 7'b1110000;
            exp_stall = stall;
            if (!ctrl[6] && stall < (1 << w) - 1) stall = stall + 1;
            age = freeze ? age + 1 : 0;
        end
    endtask

    task automatic step(input logic rst_v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [2:0] dmrd,
                        input logic rfwr, input logic [4:0] rd, input logic div,
                        input logic redir);
        exp_t e;
        @(posedge clk);
        #1;
        rstn = rst_v; IFID_rs = rs; IFID_rt = rt; IFID_use_rs = urs; IFID_use_rt = urt;
        IDEXE_DMRd = dmrd; IDEXE_RFWr = rfwr; IDEXE_rd = rd; EXE_div = div; EXE_redirect = redir;
        model(LAT_A, W_A, age_a, stl_a, e.ctrl_a, e.stall_a);
        model(LAT_B, W_B, age_b, stl_b, e.ctrl_b, e.stall_b);
        sb_q.push_back(e);
    endtask

    task automatic idle_step(input logic rst_v, input logic div);
        step(rst_v, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, div, 1'b0);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd7;
            3: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Monitor: every cycle the DUT presents a response; compare at negedge.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {pcwr_a, ifidwr_a, idexewr_a, ifid_fl_a, idexe_fl_a, exemem_fl_a, busy_a};
                n_cmp++;
                if (act !== e.ctrl_a) begin
                    n_fail++;
                    $display("FAIL ctrl_a t=%0t act=%b req=%b", $time, act, e.ctrl_a);
                end
                n_cmp++;
                if (32'(stall_a) !== e.stall_a) begin
                    n_fail++;
                    $display("FAIL stall_a t=%0t act=%0d req=%0d", $time, stall_a, e.stall_a);
                end
                act = {pcwr_b, ifidwr_b, idexewr_b, ifid_fl_b, idexe_fl_b, exemem_fl_b, busy_b};
                n_cmp++;
                if (act !== e.ctrl_b) begin
                    n_fail++;
                    $display("FAIL ctrl_b t=%0t act=%b req=%b", $time, act, e.ctrl_b);
                end
                n_cmp++;
                if (32'(stall_b) !== e.stall_b) begin
                    n_fail++;
                    $display("FAIL stall_b t=%0t act=%0d req=%0d", $time, stall_b, e.stall_b);
                end
            end
        end
    end

    // Time bound: report and still print the summary.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout act=running req=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        rstn = 1'b0; IFID_rs = 5'd0; IFID_rt = 5'd0; IFID_use_rs = 1'b0; IFID_use_rt = 1'b0;
        IDEXE_DMRd = 3'd0; IDEXE_RFWr = 1'b0; IDEXE_rd = 5'd0; EXE_div = 1'b0; EXE_redirect = 1'b0;

        // reset state, even with a divide present
        idle_step(1'b0, 1'b0);
        idle_step(1'b0, 1'b1);
        idle_step(1'b1, 1'b0);

        // load-use on rs, then bubble
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 3'd1, 1'b1, 5'd5, 1'b0, 1'b0);
        idle_step(1'b1, 1'b0);
        // rd=0 never stalls; rt match with use_rt=0 does not stall; rt with use_rt=1 does
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 3'd2, 1'b1, 5'd0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd7, 1'b0, 1'b0, 3'd2, 1'b1, 5'd7, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd31, 1'b0, 1'b1, 3'd3, 1'b1, 5'd31, 1'b0, 1'b0);
        idle_step(1'b1, 1'b0);

        // single divide from a clean counter
        idle_step(1'b0, 1'b0);
        for (int i = 0; i < LAT_A; i++) idle_step(1'b1, 1'b1);
        idle_step(1'b1, 1'b0);

        // back-to-back divides
        idle_step(1'b0, 1'b0);
        for (int i = 0; i < 2 * LAT_A; i++) idle_step(1'b1, 1'b1);
        idle_step(1'b1, 1'b0);

        // redirect together with load-use
        step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 3'd1, 1'b1, 5'd9, 1'b0, 1'b1);
        // redirect during a freeze is ignored
        step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 3'd1, 1'b1, 5'd9, 1'b1, 1'b1);
        step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 3'd1, 1'b1, 5'd9, 1'b1, 1'b1);
        for (int i = 0; i < LAT_A; i++) idle_step(1'b1, 1'b0);

        // reset asserted in freeze cycle 3, released with no divide
        idle_step(1'b1, 1'b1);
        idle_step(1'b1, 1'b1);
        idle_step(1'b0, 1'b1);
        idle_step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_step(1'b1, 1'b0);

        // long divide run saturates the 4-bit counter
        for (int i = 0; i < 3 * LAT_A; i++) idle_step(1'b1, 1'b1);
        idle_step(1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 pick_reg(), pick_reg(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                 1'($urandom_range(0, 3) != 0), pick_reg(),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
        end

        // drain the scoreboard
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain act=%0d req=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
